pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 17 +
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default widths for the pipeline controller.
//   ctrl_state_t : controller state encoding (RUN / MEM_WAIT / HALT)
//   DEF_*        : default counter widths
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

  localparam int DEF_CNT_WIDTH       = 32;
  localparam int DEF_FLUSH_CNT_WIDTH = 16;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones.
//   clk, rst_n : clock, async active-low reset (clears count)
//   en         : advance by one this edge (ignored once saturated)
//   count      : current value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller for a 5-stage core.
//   clk, rst_n            : clock, async active-low reset
//   hz_stall, hz_flush    : load-use stall / redirect from hazard unit
//   dmem_req, dmem_ack    : MEM-stage access present / completing
//   ext_halt, halt_resume : debug halt level / resume pulse
//   *_en, *_clr           : per-stage load enables and bubble inserts
//   ctrl_state            : current state (0 RUN, 1 MEM_WAIT, 2 HALT)
//   stall_cycles          : saturating count of edges with pc_en=0
//   flush_count           : saturating count of applied flushes
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int FLUSH_CNT_WIDTH = DEF_FLUSH_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hz_stall,
  input  logic                       hz_flush,
  input  logic                       dmem_req,
  input  logic                       dmem_ack,
  input  logic                       ext_halt,
  input  logic                       halt_resume,
  output logic                       pc_en,
  output logic                       if_id_en,
  output logic                       id_ex_en,
  output logic                       ex_mem_en,
  output logic                       mem_wb_en,
  output logic                       if_id_clr,
  output logic                       id_ex_clr,
  output logic                       mem_wb_clr,
  output logic [1:0]                 ctrl_state,
  output logic [CNT_WIDTH-1:0]       stall_cycles,
  output logic [FLUSH_CNT_WIDTH-1:0] flush_count
);
  ctrl_state_t state, state_nxt;
  logic        mem_wait;
  logic        flush_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_wait   = 1'b0;
    flush_hit  = 1'b0;
    pc_en      = 1'b0;
    if_id_en   = 1'b0;
    id_ex_en   = 1'b0;
    ex_mem_en  = 1'b0;
    mem_wb_en  = 1'b0;
    if_id_clr  = 1'b0;
    id_ex_clr  = 1'b0;
    mem_wb_clr = 1'b0;
    // Outputs stay all-zero while reset is asserted.
    if (rst_n) begin
      case (state)
        HALT: begin
          mem_wb_en  = 1'b1;
          mem_wb_clr = 1'b1;
          if (halt_resume) state_nxt = RUN;
        end
        default: begin // RUN, MEM_WAIT, and unused encoding 3 (acts as RUN)
          // Once in MEM_WAIT the request is implied; only the ack matters.
          mem_wait = (state == MEM_WAIT) ? !dmem_ack : (dmem_req && !dmem_ack);
          if (mem_wait) begin
            // Freeze front of pipe, drain MEM->WB with a bubble.
            mem_wb_en  = 1'b1;
            mem_wb_clr = 1'b1;
            state_nxt  = MEM_WAIT;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (hz_flush) begin
              // Flush wins; a coincident load-use stall is moot after redirect.
              if_id_clr = 1'b1;
              id_ex_clr = 1'b1;
              flush_hit = 1'b1;
            end else if (hz_stall) begin
              pc_en     = 1'b0;
              if_id_en  = 1'b0;
              id_ex_clr = 1'b1;
            end
            state_nxt = ext_halt ? HALT : RUN;
          end
        end
      endcase
    end
  end

  assign ctrl_state = state;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!pc_en),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(FLUSH_CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_hit),
    .count (flush_count)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (small counter widths to reach saturation).
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hz_stall = 1'b0, hz_flush = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic ext_halt = 1'b0, halt_resume = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_clr, id_ex_clr, mem_wb_clr;
  logic [1:0] ctrl_state;
  logic [3:0] stall_cycles;
  logic [1:0] flush_count;

  pipeline_ctrl #(.CNT_WIDTH(4), .FLUSH_CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .hz_flush(hz_flush),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .ext_halt(ext_halt),
    .halt_resume(halt_resume), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr), .mem_wb_clr(mem_wb_clr),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] en;   // pc, if_id, id_ex, ex_mem, mem_wb
    logic [2:0] clr;  // if_id, id_ex, mem_wb
    logic [1:0] st;
    logic [3:0] sc;
    logic [1:0] fc;
  } exp_t;

  // Output patterns
  localparam logic [4:0] E_RST = 5'b00000, E_ALL = 5'b11111, E_MW = 5'b00001, E_HS = 5'b00111;
  localparam logic [2:0] C_NO = 3'b000, C_FL = 3'b110, C_MW = 3'b001, C_HS = 3'b010;

  exp_t exp_q[$];
  int   vec_id_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_issued = 0;

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic v(input logic rst, stl, fls, req, ack, hlt, res,
                   input logic [4:0] en, input logic [2:0] clr,
                   input logic [1:0] st, input int sc, input int fc);
    exp_t e;
    @(posedge clk); #1;
    rst_n = rst; hz_stall = stl; hz_flush = fls; dmem_req = req;
    dmem_ack = ack; ext_halt = hlt; halt_resume = res;
    e.en = en; e.clr = clr; e.st = st; e.sc = 4'(sc); e.fc = 2'(fc);
    exp_q.push_back(e);
    vec_id_q.push_back(n_issued);
    n_issued++;
  endtask

  // Monitor: outputs are present every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      int id;
      e  = exp_q.pop_front();
      id = vec_id_q.pop_front();
      a.en  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
      a.clr = {if_id_clr, id_ex_clr, mem_wb_clr};
      a.st  = ctrl_state;
      a.sc  = stall_cycles;
      a.fc  = flush_count;
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got en=%b clr=%b st=%0d sc=%0d fc=%0d, need en=%b clr=%b st=%0d sc=%0d fc=%0d",
                 id, a.en, a.clr, a.st, a.sc, a.fc, e.en, e.clr, e.st, e.sc, e.fc);
      end
    end
  end

  initial begin
    //  rst stl fls req ack hlt res   en     clr   st sc fc
    v(0, 0, 0, 0, 0, 0, 0, E_RST, C_NO, 0, 0, 0);   // in reset
    v(0, 0, 0, 0, 0, 0, 0, E_RST, C_NO, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0, E_ALL, C_NO, 0, 0, 0);   // idle RUN
    v(1, 1, 0, 0, 0, 0, 0, E_HS,  C_HS, 0, 0, 0);   // load-use stall
    v(1, 0, 0, 0, 0, 0, 0, E_ALL, C_NO, 0, 1, 0);
    v(1, 1, 1, 0, 0, 0, 0, E_ALL, C_FL, 0, 1, 0);   // flush beats stall
    v(1, 0, 0, 0, 0, 0, 0, E_ALL, C_NO, 0, 1, 1);
    v(1, 0, 0, 1, 0, 0, 0, E_MW,  C_MW, 0, 1, 1);   // miss -> MEM_WAIT
    v(1, 1, 1, 1, 0, 0, 0, E_MW,  C_MW, 1, 2, 1);   // hazards ignored in wait
    v(1, 0, 0, 1, 0, 0, 0, E_MW,  C_MW, 1, 3, 1);
    v(1, 0, 0, 1, 1, 0, 0, E_ALL, C_NO, 1, 4, 1);   // ack: behaves as RUN
    v(1, 0, 0, 0, 0, 0, 0, E_ALL, C_NO, 0, 4, 1);
    v(1, 0, 1, 1, 1, 0, 0, E_ALL, C_FL, 0, 4, 1);   // single-cycle access + flush
    v(1, 0, 0, 1, 0, 1, 0, E_MW,  C_MW, 0, 4, 2);   // halt deferred by miss
    v(1, 0, 0, 1, 0, 1, 0, E_MW,  C_MW, 1, 5, 2);
    v(1, 1, 0, 1, 1, 1, 0, E_HS,  C_HS, 1, 6, 2);   // ack + stall, then HALT
    v(1, 0, 1, 1, 0, 1, 0, E_MW,  C_MW, 2, 7, 2);   // HALT ignores hz/dmem
    v(1, 0, 0, 0, 0, 1, 1, E_MW,  C_MW, 2, 8, 2);   // resume
    v(1, 0, 0, 0, 0, 1, 0, E_ALL, C_NO, 0, 9, 2);   // RUN entry, halt still high
    v(1, 0, 0, 0, 0, 0, 0, E_MW,  C_MW, 2, 9, 2);   // back in HALT
    v(0, 0, 0, 0, 0, 0, 0, E_RST, C_NO, 0, 0, 0);   // async reset in HALT
    v(1, 0, 1, 0, 0, 0, 0, E_ALL, C_FL, 0, 0, 0);   // first cycle after release
    v(1, 0, 1, 0, 0, 0, 0, E_ALL, C_FL, 0, 0, 1);
    v(1, 0, 1, 0, 0, 0, 0, E_ALL, C_FL, 0, 0, 2);
    v(1, 0, 1, 0, 0, 0, 0, E_ALL, C_FL, 0, 0, 3);   // flush count saturated
    v(1, 0, 0, 0, 0, 0, 0, E_ALL, C_NO, 0, 0, 3);
    for (int i = 0; i < 20; i++)                    // stall count saturates at 15
      v(1, 1, 0, 0, 0, 0, 0, E_HS, C_HS, 0, (i < 15) ? i : 15, 3);
    v(1, 0, 0, 0, 0, 0, 0, E_ALL, C_NO, 0, 15, 3);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
